// File: rtl/ex2_sad_min_tracker_pkg.sv
// Shared custom-instruction definitions for the EX2 SAD minimum tracker:
// search FSM encoding and the SAD reset value.
package ex2_sad_min_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [31:0] SAD_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/ex2_sad_min_tracker_sad_compare.sv
// Unsigned 32-bit less-than used to decide whether a candidate beats the
// current best SAD.
module sad_compare (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);

    assign lt = (a < b);

endmodule

// File: rtl/ex2_sad_min_tracker.sv
// Tracks the minimum SAD and its window coordinates over a search of
// NumCand candidates coming out of the EX2 stage.
module ex2_sad_min_tracker
    import ex2_sad_min_tracker_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] NumCand,
    input  logic        SadValid,
    input  logic [31:0] Sad_EX2,
    input  logic [31:0] OutX_EX2,
    input  logic [31:0] OutY_EX2,
    input  logic        ResultReady,
    output logic        ResultValid,
    output logic [31:0] BestSad,
    output logic [31:0] BestX,
    output logic [31:0] BestY,
    output logic [15:0] CandCount,
    output logic        Busy
);

    // Handshake: the result transfers on the edge where ResultValid and
    // ResultReady are both high; until then ResultValid and the Best* outputs
    // hold, and the transfer edge returns the FSM to IDLE.

    state_t      state;
    logic [15:0] num_cand_q;
    logic        sad_lt;
    logic [15:0] cand_next;

    sad_compare u_sad_compare (
        .a  (Sad_EX2),
        .b  (BestSad),
        .lt (sad_lt)
    );

    assign cand_next   = CandCount + 16'd1;
    assign ResultValid = (state == DONE);
    assign Busy        = (state == ACCUM);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            BestSad    <= SAD_INIT;
            BestX      <= 32'd0;
            BestY      <= 32'd0;
            CandCount  <= 16'd0;
            num_cand_q <= 16'd0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (Start) begin
                        BestSad    <= SAD_INIT;
                        BestX      <= 32'd0;
                        BestY      <= 32'd0;
                        CandCount  <= 16'd0;
                        num_cand_q <= NumCand;
                        state      <= (NumCand == 16'd0) ? DONE : ACCUM;
                    end else if (state == ACCUM && SadValid) begin
                        // Strict less-than keeps the earliest candidate on ties.
                        CandCount <= cand_next;
                        if (sad_lt) begin
                            BestSad <= Sad_EX2;
                            BestX   <= OutX_EX2;
                            BestY   <= OutY_EX2;
                        end
                        if (cand_next == num_cand_q)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (ResultReady)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
